// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types for the fetch/data memory arbiter: FSM state
//                encoding, requester identifiers and counter sizing.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Which requester currently owns (or last owned) the memory port
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } requester_t;

    // Access-length down-counter width; covers latencies 1..15
    localparam int CNT_WIDTH = 4;

    // The requester that is not r
    function automatic requester_t otherRequester(input requester_t r);
        return (r == REQ_IF) ? REQ_D : REQ_IF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the fetch requester, data requester, single-port
//                memory and hazard-unit signals around the memory arbiter.
//                "slave" is the arbiter's view, "master" the environment's.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    // Fetch-stage requester
    logic                     ifReq_i;
    logic [ADDRESS_WIDTH-1:0] ifAddr_i;
    logic [DATA_WIDTH-1:0]    ifRdata_o;
    logic                     ifAck_o;

    // Memory-stage requester
    logic                     dReq_i;
    logic                     dWe_i;
    logic [ADDRESS_WIDTH-1:0] dAddr_i;
    logic [DATA_WIDTH-1:0]    dWdata_i;
    logic [DATA_WIDTH-1:0]    dRdata_o;
    logic                     dAck_o;

    // Shared single-port memory
    logic                     memEn_o;
    logic                     memWe_o;
    logic [ADDRESS_WIDTH-1:0] memAddr_o;
    logic [DATA_WIDTH-1:0]    memWdata_o;
    logic [DATA_WIDTH-1:0]    memRdata_i;

    // Hazard unit / status
    logic                     stallF_o;
    logic                     stallM_o;
    logic                     busy_o;

    modport slave (
        input  ifReq_i, ifAddr_i, dReq_i, dWe_i, dAddr_i, dWdata_i, memRdata_i,
        output ifRdata_o, ifAck_o, dRdata_o, dAck_o,
               memEn_o, memWe_o, memAddr_o, memWdata_o,
               stallF_o, stallM_o, busy_o
    );

    modport master (
        output ifReq_i, ifAddr_i, dReq_i, dWe_i, dAddr_i, dWdata_i, memRdata_i,
        input  ifRdata_o, ifAck_o, dRdata_o, dAck_o,
               memEn_o, memWe_o, memAddr_o, memWdata_o,
               stallF_o, stallM_o, busy_o
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port memory between the instruction-fetch
//                and data requesters. IDLE -> ACCESS (MEM_LATENCY cycles) ->
//                RESPOND (one-cycle ack). Data wins contention unless data
//                was the previous grant. MEM_LATENCY must be within 1..15.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_LATENCY   = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,     // asynchronous, active-low
    mem_arbiter_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] c_LOAD = CNT_WIDTH'(MEM_LATENCY);
    localparam logic [CNT_WIDTH-1:0] c_ONE  = CNT_WIDTH'(1);

    state_t                   r_state;
    state_t                   w_nextState;
    requester_t               r_grant;      // current owner, doubles as last grant
    requester_t               w_grantSel;
    logic                     w_doGrant;
    logic [CNT_WIDTH-1:0]     r_cnt;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH-1:0] w_selAddr;
    logic                     r_we;
    logic                     w_selWe;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    w_selWdata;
    logic [DATA_WIDTH-1:0]    r_ifRdata;
    logic [DATA_WIDTH-1:0]    r_dRdata;
    logic                     w_lastAccess;
    logic                     w_ifAck;
    logic                     w_dAck;

    // Final ACCESS cycle: the counter has one cycle left (<= guards a zero load)
    assign w_lastAccess = (r_state == ACCESS) && (r_cnt <= c_ONE);

    // Next-state and grant decision
    always_comb begin
        w_nextState = r_state;
        w_doGrant   = 1'b0;
        w_grantSel  = r_grant;
        case (r_state)
            IDLE: begin
                if (bus.ifReq_i && bus.dReq_i) begin
                    // Contention: data normally wins, but yields right after its own grant
                    w_doGrant  = 1'b1;
                    w_grantSel = (r_grant == REQ_D) ? REQ_IF : REQ_D;
                end else if (bus.dReq_i) begin
                    w_doGrant  = 1'b1;
                    w_grantSel = REQ_D;
                end else if (bus.ifReq_i) begin
                    w_doGrant  = 1'b1;
                    w_grantSel = REQ_IF;
                end
                if (w_doGrant) begin
                    w_nextState = ACCESS;
                end
            end
            ACCESS: begin
                if (w_lastAccess) begin
                    w_nextState = RESPOND;
                end
            end
            RESPOND: begin
                // Only the requester that was not just served may chain straight in
                w_nextState = IDLE;
                if ((r_grant == REQ_IF) ? bus.dReq_i : bus.ifReq_i) begin
                    w_doGrant   = 1'b1;
                    w_grantSel  = otherRequester(r_grant);
                    w_nextState = ACCESS;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Request fields of whichever requester is being granted; fetches never write
    always_comb begin
        w_selAddr  = bus.ifAddr_i;
        w_selWe    = 1'b0;
        w_selWdata = '0;
        if (w_grantSel == REQ_D) begin
            w_selAddr  = bus.dAddr_i;
            w_selWe    = bus.dWe_i;
            w_selWdata = bus.dWdata_i;
        end
    end

    // State, grant owner and access-length counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_grant <= REQ_IF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_doGrant) begin
                r_grant <= w_grantSel;
                r_cnt   <= c_LOAD;
            end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_ONE;
            end
        end
    end

    // Latch the granted request; held stable for the whole access
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_doGrant) begin
            r_addr  <= w_selAddr;
            r_we    <= w_selWe;
            r_wdata <= w_selWdata;
        end
    end

    // Capture read data into the owner's register on the final access cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ifRdata <= '0;
            r_dRdata  <= '0;
        end else if (w_lastAccess && !r_we) begin
            if (r_grant == REQ_IF) begin
                r_ifRdata <= bus.memRdata_i;
            end else begin
                r_dRdata <= bus.memRdata_i;
            end
        end
    end

    // Ack only while the owner still requests; a flushed request gets no ack
    assign w_ifAck = (r_state == RESPOND) && (r_grant == REQ_IF) && bus.ifReq_i;
    assign w_dAck  = (r_state == RESPOND) && (r_grant == REQ_D)  && bus.dReq_i;

    assign bus.ifAck_o    = w_ifAck;
    assign bus.dAck_o     = w_dAck;
    assign bus.ifRdata_o  = r_ifRdata;
    assign bus.dRdata_o   = r_dRdata;
    assign bus.memEn_o    = (r_state == ACCESS);
    assign bus.memWe_o    = (r_state == ACCESS) && r_we;
    assign bus.memAddr_o  = r_addr;
    assign bus.memWdata_o = r_wdata;
    assign bus.stallF_o   = bus.ifReq_i & ~w_ifAck;
    assign bus.stallM_o   = bus.dReq_i & ~w_dAck;
    assign bus.busy_o     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed scenarios plus
//                randomized traffic against a scoreboard memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int L         = 2;
    localparam int STALL_MAX = 2 * (L + 1);

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .MEM_LATENCY  (L)
    ) dut (
        .clk_i(clk),
        .rst_i(rstN),
        .bus  (bus)
    );

    // ---------------- memory device and reference contents ----------------
    logic [DW-1:0] tbMem  [logic [AW-1:0]];   // what the DUT actually wrote
    logic [DW-1:0] refMem [logic [AW-1:0]];   // what the requesters expect
    int enCnt = 0;

    function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'h00A00513;
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    function automatic logic [DW-1:0] memRead(input logic [AW-1:0] a);
        if (tbMem.exists(a)) return tbMem[a];
        return initVal(a);
    endfunction

    function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
        if (refMem.exists(a)) return refMem[a];
        return initVal(a);
    endfunction

    // Memory commits a write and counts enabled cycles of the current access
    always @(posedge clk) begin
        if (bus.memEn_o) begin
            if (bus.memWe_o && enCnt == L - 1) tbMem[bus.memAddr_o] = bus.memWdata_o;
            enCnt <= enCnt + 1;
        end else begin
            enCnt <= 0;
        end
    end

    // Read data is valid only in the MEM_LATENCY-th enabled cycle, garbage otherwise
    always @(negedge clk) begin
        bus.memRdata_i = (bus.memEn_o && enCnt == L - 1) ? memRead(bus.memAddr_o)
                                                         : (32'hBAD0_0000 ^ 32'(enCnt));
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.memEn_o !== 1'b0 || bus.memWe_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: memEn=%b memWe=%b busy=%b, required 0 0 0", bus.memEn_o, bus.memWe_o, bus.busy_o);
        end
        checks++;
        if (bus.ifAck_o !== 1'b0 || bus.dAck_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack: ifAck=%b dAck=%b, required 0 0", bus.ifAck_o, bus.dAck_o);
        end
        checks++;
        if (bus.memAddr_o !== '0 || bus.memWdata_o !== '0) begin
            errors++;
            $display("FAIL reset_bus: memAddr=%h memWdata=%h, required 0 0", bus.memAddr_o, bus.memWdata_o);
        end
        checks++;
        if (bus.ifRdata_o !== '0 || bus.dRdata_o !== '0) begin
            errors++;
            $display("FAIL reset_rdata: ifRdata=%h dRdata=%h, required 0 0", bus.ifRdata_o, bus.dRdata_o);
        end
        rstN = 1'b1;
    endtask

    task automatic test_fetch();
        int ackAt = -1;
        logic [DW-1:0] got = '0;
        bus.ifReq_i  = 1'b1;
        bus.ifAddr_i = 32'h10;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (bus.memEn_o !== (k <= L) || bus.busy_o !== (k <= L + 1)) begin
                errors++;
                $display("FAIL fetch_timing k=%0d: memEn=%b busy=%b, required %b %b", k, bus.memEn_o, bus.busy_o, (k <= L), (k <= L + 1));
            end
            if (k <= L) begin
                checks++;
                if (bus.memAddr_o !== 32'h10 || bus.memWe_o !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_bus k=%0d: memAddr=%h memWe=%b, required 00000010 0", k, bus.memAddr_o, bus.memWe_o);
                end
            end
            if (bus.ifAck_o) begin
                if (ackAt < 0) ackAt = k;
                got = bus.ifRdata_o;
                bus.ifReq_i = 1'b0;
            end
        end
        checks++;
        if (ackAt != L + 1 || got !== 32'h00A00513) begin
            errors++;
            $display("FAIL fetch_ack: ackCycle=%0d data=%h, required %0d 00a00513", ackAt, got, L + 1);
        end
    endtask

    task automatic test_contention();
        int dAt = -1, fAt = -1, enInAck = 0;
        logic [DW-1:0] dGot = '0, fGot = '0;
        bus.ifReq_i = 1'b1; bus.ifAddr_i = 32'h14;
        bus.dReq_i  = 1'b1; bus.dWe_i = 1'b0; bus.dAddr_i = 32'h100; bus.dWdata_i = '0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if ((bus.ifAck_o || bus.dAck_o) && bus.memEn_o) enInAck++;
            if (bus.dAck_o) begin
                if (dAt < 0) dAt = k;
                dGot = bus.dRdata_o;
                bus.dReq_i = 1'b0;
            end
            if (bus.ifAck_o) begin
                if (fAt < 0) fAt = k;
                fGot = bus.ifRdata_o;
                bus.ifReq_i = 1'b0;
            end
        end
        checks++;
        if (dAt != L + 1 || fAt != 2 * (L + 1)) begin
            errors++;
            $display("FAIL contention_order: dAck at %0d ifAck at %0d, required %0d %0d", dAt, fAt, L + 1, 2 * (L + 1));
        end
        checks++;
        if (dGot !== refRead(32'h100) || fGot !== refRead(32'h14)) begin
            errors++;
            $display("FAIL contention_data: d=%h if=%h, required %h %h", dGot, fGot, refRead(32'h100), refRead(32'h14));
        end
        checks++;
        if (enInAck != 0) begin
            errors++;
            $display("FAIL contention_respond_en: memEn high in %0d ack cycles, required 0", enInAck);
        end
    endtask

    task automatic test_write();
        int ackAt = -1;
        logic [DW-1:0] rdAtAck = '0;
        bus.dReq_i = 1'b1; bus.dWe_i = 1'b1; bus.dAddr_i = 32'h20; bus.dWdata_i = 32'hDEADBEEF;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k <= L) begin
                checks++;
                if (bus.memEn_o !== 1'b1 || bus.memWe_o !== 1'b1 || bus.memAddr_o !== 32'h20 || bus.memWdata_o !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL write_bus k=%0d: en=%b we=%b addr=%h wdata=%h, required 1 1 00000020 deadbeef",
                             k, bus.memEn_o, bus.memWe_o, bus.memAddr_o, bus.memWdata_o);
                end
            end
            if (k == 1) begin
                // changes during the access must be ignored
                bus.dAddr_i = 32'h24; bus.dWdata_i = 32'h1234_5678; bus.dWe_i = 1'b0;
            end
            if (bus.dAck_o) begin
                if (ackAt < 0) ackAt = k;
                rdAtAck = bus.dRdata_o;
                bus.dReq_i = 1'b0;
            end
        end
        refMem[32'h20] = 32'hDEADBEEF;
        checks++;
        if (ackAt != L + 1 || rdAtAck !== refRead(32'h100)) begin
            errors++;
            $display("FAIL write_ack: ackCycle=%0d dRdata=%h, required %0d %h", ackAt, rdAtAck, L + 1, refRead(32'h100));
        end
        checks++;
        if (memRead(32'h20) !== 32'hDEADBEEF || tbMem.exists(32'h24)) begin
            errors++;
            $display("FAIL write_mem: mem[20]=%h wrote24=%0d, required deadbeef 0", memRead(32'h20), tbMem.exists(32'h24));
        end
    endtask

    task automatic test_flush();
        int fAcks = 0, dAcks = 0;
        bus.ifReq_i = 1'b1; bus.ifAddr_i = 32'h30;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (bus.ifAck_o) fAcks++;
            if (k == 2) bus.ifReq_i = 1'b0;
            if (k == L + 1) begin
                checks++;
                if (bus.busy_o !== 1'b1 || bus.memEn_o !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_respond: busy=%b memEn=%b, required 1 0", bus.busy_o, bus.memEn_o);
                end
            end
        end
        checks++;
        if (fAcks != 0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_fetch: acks=%0d busy=%b, required 0 0", fAcks, bus.busy_o);
        end
        bus.dReq_i = 1'b1; bus.dWe_i = 1'b1; bus.dAddr_i = 32'h44; bus.dWdata_i = 32'hCAFEF00D;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (bus.dAck_o) dAcks++;
            if (k == 1) bus.dReq_i = 1'b0;
        end
        refMem[32'h44] = 32'hCAFEF00D;
        checks++;
        if (dAcks != 0 || memRead(32'h44) !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL flush_write: acks=%0d mem[44]=%h, required 0 cafef00d", dAcks, memRead(32'h44));
        end
    endtask

    task automatic test_reset_mid();
        int ackAt = -1, enCycles = 0;
        logic [DW-1:0] got = '0;
        bus.ifReq_i = 1'b1; bus.ifAddr_i = 32'h50;
        step();
        checks++;
        if (bus.memEn_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: memEn=%b, required 1", bus.memEn_o);
        end
        #2 rstN = 1'b0;
        #1;
        checks++;
        if (bus.memEn_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.memAddr_o !== '0 || bus.ifAck_o !== 1'b0 ||
            bus.ifRdata_o !== '0 || bus.dRdata_o !== '0) begin
            errors++;
            $display("FAIL rstmid_async: en=%b busy=%b addr=%h ack=%b ifRd=%h dRd=%h, required all 0",
                     bus.memEn_o, bus.busy_o, bus.memAddr_o, bus.ifAck_o, bus.ifRdata_o, bus.dRdata_o);
        end
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (bus.memEn_o) enCycles++;
            if (bus.ifAck_o) begin
                if (ackAt < 0) ackAt = k;
                got = bus.ifRdata_o;
                bus.ifReq_i = 1'b0;
            end
        end
        checks++;
        if (enCycles != L || ackAt != L + 1 || got !== refRead(32'h50)) begin
            errors++;
            $display("FAIL rstmid_after: enCycles=%0d ackCycle=%0d data=%h, required %0d %0d %h",
                     enCycles, ackAt, got, L, L + 1, refRead(32'h50));
        end
    endtask

    task automatic test_alternation();
        int n = 0, runF = 0, runM = 0, maxF = 0, maxM = 0;
        logic [AW-1:0] fA = 32'h300, dA = 32'h340;
        bus.ifReq_i = 1'b1; bus.ifAddr_i = fA;
        bus.dReq_i  = 1'b1; bus.dWe_i = 1'b0; bus.dAddr_i = dA;
        for (int c = 0; c < 60; c++) begin
            step();
            runF = bus.stallF_o ? runF + 1 : 0;
            runM = bus.stallM_o ? runM + 1 : 0;
            if (runF > maxF) maxF = runF;
            if (runM > maxM) maxM = runM;
            if (bus.dAck_o || bus.ifAck_o) begin
                checks++;
                if (bus.dAck_o !== (n % 2 == 0)) begin
                    errors++;
                    $display("FAIL alt_order grant#%0d: dAck=%b ifAck=%b, required data=%0d", n, bus.dAck_o, bus.ifAck_o, (n % 2 == 0));
                end
                checks++;
                if (bus.dAck_o ? (bus.dRdata_o !== refRead(dA)) : (bus.ifRdata_o !== refRead(fA))) begin
                    errors++;
                    $display("FAIL alt_data grant#%0d: d=%h if=%h, required %h %h", n, bus.dRdata_o, bus.ifRdata_o, refRead(dA), refRead(fA));
                end
                if (bus.dAck_o) begin
                    dA = 32'h340 + 32'($urandom_range(0, 15)) * 32'd4;
                    bus.dAddr_i = dA;
                end else begin
                    fA = 32'h300 + 32'($urandom_range(0, 15)) * 32'd4;
                    bus.ifAddr_i = fA;
                end
                n++;
            end
        end
        bus.ifReq_i = 1'b0; bus.dReq_i = 1'b0;
        checks++;
        if (n < 16 || maxF > STALL_MAX || maxM > STALL_MAX) begin
            errors++;
            $display("FAIL alt_stall: grants=%0d maxStallF=%0d maxStallM=%0d, required >=16 <=%0d <=%0d", n, maxF, maxM, STALL_MAX, STALL_MAX);
        end
        repeat (L + 2) step();
    endtask

    task automatic test_random();
        bit fAct = 1'b0, dAct = 1'b0, dW = 1'b0, bStable = 1'b1, bWe = 1'b0, prevAck = 1'b0;
        logic [AW-1:0] fA = '0, dA = '0, bAddr = '0;
        logic [DW-1:0] dWd = '0, bWd = '0;
        int bLen = 0, runF = 0, runM = 0, maxF = 0, maxM = 0, acks = 0, waitCnt = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (bus.memEn_o) begin
                if (bLen == 0) begin
                    bAddr = bus.memAddr_o; bWe = bus.memWe_o; bWd = bus.memWdata_o;
                end else if (bus.memAddr_o !== bAddr || bus.memWe_o !== bWe || bus.memWdata_o !== bWd) begin
                    bStable = 1'b0;
                end
                bLen++;
            end
            checks++;
            if (bus.stallF_o !== (bus.ifReq_i & ~bus.ifAck_o) || bus.stallM_o !== (bus.dReq_i & ~bus.dAck_o)) begin
                errors++;
                $display("FAIL rand_stall_fn c=%0d: stallF=%b stallM=%b, required %b %b", c, bus.stallF_o, bus.stallM_o,
                         bus.ifReq_i & ~bus.ifAck_o, bus.dReq_i & ~bus.dAck_o);
            end
            checks++;
            if ((bus.ifAck_o || bus.dAck_o) && (bus.memEn_o || (bus.ifAck_o && bus.dAck_o) || prevAck)) begin
                errors++;
                $display("FAIL rand_ack_pulse c=%0d: ifAck=%b dAck=%b memEn=%b prevAck=%b, required single isolated ack",
                         c, bus.ifAck_o, bus.dAck_o, bus.memEn_o, prevAck);
            end
            prevAck = bus.ifAck_o | bus.dAck_o;
            runF = bus.stallF_o ? runF + 1 : 0;
            runM = bus.stallM_o ? runM + 1 : 0;
            if (runF > maxF) maxF = runF;
            if (runM > maxM) maxM = runM;
            if (bus.ifAck_o) begin
                checks++;
                if (!fAct || bus.ifRdata_o !== refRead(fA) || bLen != L || !bStable || bAddr !== fA || bWe !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_fetch c=%0d: data=%h addr=%h len=%0d stable=%b we=%b, required %h %h %0d 1 0",
                             c, bus.ifRdata_o, bAddr, bLen, bStable, bWe, refRead(fA), fA, L);
                end
                fAct = 1'b0; bLen = 0; bStable = 1'b1; acks++;
            end
            if (bus.dAck_o) begin
                checks++;
                if (!dAct || bLen != L || !bStable || bAddr !== dA || bWe !== dW ||
                    (dW ? (bWd !== dWd) : (bus.dRdata_o !== refRead(dA)))) begin
                    errors++;
                    $display("FAIL rand_data c=%0d: we=%b addr=%h wdata=%h rdata=%h len=%0d stable=%b, required %b %h %h %h %0d 1",
                             c, bWe, bAddr, bWd, bus.dRdata_o, bLen, bStable, dW, dA, dWd, refRead(dA), L);
                end
                if (dW) refMem[dA] = dWd;
                dAct = 1'b0; bLen = 0; bStable = 1'b1; acks++;
            end
            if (!fAct && $urandom_range(0, 1) == 1) begin
                fAct = 1'b1;
                fA = 32'h200 + 32'($urandom_range(0, 15)) * 32'd4;
            end
            if (!dAct && $urandom_range(0, 1) == 1) begin
                dAct = 1'b1;
                dA  = 32'h200 + 32'($urandom_range(0, 15)) * 32'd4;
                dW  = 1'($urandom_range(0, 1));
                dWd = $urandom;
            end
            bus.ifReq_i  = fAct;
            bus.ifAddr_i = fAct ? fA : $urandom;
            bus.dReq_i   = dAct;
            bus.dAddr_i  = dAct ? dA : $urandom;
            bus.dWe_i    = dAct ? dW : 1'($urandom_range(0, 1));
            bus.dWdata_i = dAct ? dWd : $urandom;
        end
        checks++;
        if (acks < 60 || maxF > STALL_MAX || maxM > STALL_MAX) begin
            errors++;
            $display("FAIL rand_progress: acks=%0d maxStallF=%0d maxStallM=%0d, required >=60 <=%0d <=%0d", acks, maxF, maxM, STALL_MAX, STALL_MAX);
        end
        bus.ifReq_i = 1'b0; bus.dReq_i = 1'b0;
        while (bus.busy_o && waitCnt < 10) begin
            step();
            waitCnt++;
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: busy=%b after %0d cycles, required 0", bus.busy_o, waitCnt);
        end
    endtask

    initial begin
        bus.ifReq_i  = 1'b0;
        bus.ifAddr_i = '0;
        bus.dReq_i   = 1'b0;
        bus.dWe_i    = 1'b0;
        bus.dAddr_i  = '0;
        bus.dWdata_i = '0;
        test_reset();
        test_fetch();
        test_contention();
        test_write();
        test_flush();
        test_reset_mid();
        test_alternation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 32: width of all addresses.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: width of all data words.
REQ-003 The block SHALL have parameter MEM_LATENCY, default 2: cycles from memory issue to valid memRdata_i, legal range 1..15.
REQ-004 clk_i  input  1  single clock; all state changes on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-low.
REQ-006 ifReq_i  input  1  fetch-stage read request, held until ifAck_o.
REQ-007 ifAddr_i  input  ADDRESS_WIDTH  fetch address (pcF).
REQ-008 ifRdata_o  output  DATA_WIDTH  fetched instruction word, valid with ifAck_o.
REQ-009 ifAck_o  output  1  one-cycle fetch completion pulse.
REQ-010 dReq_i  input  1  memory-stage request, held until dAck_o.
REQ-011 dWe_i  input  1  1 = write, 0 = read (MemWriteM).
REQ-012 dAddr_i  input  ADDRESS_WIDTH  data address (ALUResultM).
REQ-013 dWdata_i  input  DATA_WIDTH  store data.
REQ-014 dRdata_o  output  DATA_WIDTH  load data, valid with dAck_o.
REQ-015 dAck_o  output  1  one-cycle data completion pulse.
REQ-016 memEn_o, memWe_o  output  1 each  single-port memory enable and write enable.
REQ-017 memAddr_o  output  ADDRESS_WIDTH; memWdata_o  output  DATA_WIDTH; memRdata_i  input  DATA_WIDTH.
REQ-018 stallF_o, stallM_o  output  1 each  pipeline stall to hazard unit (fetch, memory stage).
REQ-019 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-020 The block SHALL share one single-port memory between fetch and data requesters via FSM states IDLE, ACCESS, RESPOND.
REQ-021 IDLE: if any request is pending, the block SHALL latch requester id, address, we, wdata and go to ACCESS; otherwise it stays in IDLE.
REQ-022 IDLE arbitration: data wins when both requests are pending, except that fetch wins when the previous grant was data (alternation on contention).
REQ-023 ACCESS SHALL last exactly MEM_LATENCY cycles, counted by a 4-bit down-counter, with memEn_o=1 and memAddr_o/memWe_o/memWdata_o driven from the latched values and stable throughout.
REQ-024 On the last ACCESS cycle, memRdata_i SHALL be captured into the granted requester's rdata register; writes capture nothing.
REQ-025 RESPOND SHALL last one cycle, with the granted requester's ack=1 and memEn_o=0.
REQ-026 Latency: request first seen in IDLE at edge t -> ACCESS at t+1..t+MEM_LATENCY -> ack at cycle t+MEM_LATENCY+1.
REQ-027 RESPOND -> ACCESS directly if the non-acked requester is pending; otherwise RESPOND -> IDLE. The acked requester SHALL NOT be re-granted from RESPOND.
REQ-028 stallF_o SHALL equal ifReq_i & ~ifAck_o, and stallM_o SHALL equal dReq_i & ~dAck_o (combinational).
REQ-029 A request deasserted mid-access (flush) SHALL NOT abort the access: a write still completes to memory, and the ack SHALL be suppressed if the request is low in RESPOND.
REQ-030 ifRdata_o and dRdata_o SHALL hold their last captured value until the next capture.
REQ-031 The block SHALL change latched request values only on a grant; input changes during ACCESS SHALL be ignored.

Reset
REQ-032 Asserting rst_i low SHALL immediately force IDLE, counter=0, and last-grant=fetch.
REQ-033 Reset values SHALL be: memEn_o, memWe_o, ifAck_o, dAck_o, busy_o = 0; memAddr_o, memWdata_o, ifRdata_o, dRdata_o = 0.
REQ-034 Reset mid-ACCESS SHALL abandon the access with no ack, and a write issued in that access is not guaranteed.
REQ-035 The block SHALL first accept a request on the first rising edge after rst_i deasserts.

Structure
REQ-036 The shared package mem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RESPOND) and the requester enum (REQ_IF, REQ_D).
REQ-037 The block SHALL be implemented flat with no sub-module; the counter and arbitration are local to the module.

Verification
REQ-038 MEM_LATENCY=2, ifReq_i=1 with ifAddr_i=0x0000_0010 at t0, memory returns 0x00A00513 -> memEn_o high at t1–t2, ifAck_o=1 with ifRdata_o=0x00A00513 at t3.
REQ-039 ifReq_i and dReq_i (read 0x100) both rise at t0 -> data granted first, dAck_o at t3, fetch granted from RESPOND, ifAck_o at t6, memEn_o never asserted in RESPOND.
REQ-040 dReq_i with dWe_i=1, dAddr_i=0x20, dWdata_i=0xDEADBEEF -> memWe_o=1, memAddr_o=0x20, memWdata_o=0xDEADBEEF for 2 cycles, dAck_o pulse, dRdata_o unchanged.
REQ-041 ifReq_i dropped on the second ACCESS cycle -> FSM completes, no ifAck_o, IDLE next, busy_o low.
REQ-042 rst_i low mid-ACCESS -> outputs at reset values asynchronously; after release, a fetch request is served with full MEM_LATENCY.
REQ-043 dReq_i held continuously with fetch pending -> grants alternate D, IF, D, IF, and stallF_o is never high longer than 2·(MEM_LATENCY+1) cycles.
